// File: rtl/csa_seq_adder_if.sv
// Request/result bundle for csa_seq_adder: start/a/b/ci in, busy/done/sum/co out.
// master drives requests and observes results; slave is the adder side.
interface csa_seq_adder_if #(
    parameter int WIDTH  = 4,
    parameter int CHUNKS = 4
);
    localparam int N = WIDTH * CHUNKS;

    logic         start;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         ci;
    logic         busy;
    logic         done;
    logic [N-1:0] sum;
    logic         co;

    modport master (
        output start, a, b, ci,
        input  busy, done, sum, co
    );

    modport slave (
        input  start, a, b, ci,
        output busy, done, sum, co
    );
endinterface

// File: rtl/csa_seq_adder.sv
// Multi-cycle adder: one CSA slice per clock, LSB slice first, carry registered.
// Ports: clk, rst_n (async low), bus (slave: start,a,b,ci -> busy,done,sum,co).
// Build option CSA_SEQ_SAT_EN: saturate sum to all ones when the final carry is set.
module csa #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic [WIDTH-1:0] s,
    output logic             co
);
    logic [WIDTH:0] r0;
    logic [WIDTH:0] r1;

    // carry-select: both carry-in cases computed, ci picks one
    assign r0 = {1'b0, a} + {1'b0, b};
    assign r1 = {1'b0, a} + {1'b0, b} + (WIDTH + 1)'(1);
    assign {co, s} = ci ? r1 : r0;
endmodule

module csa_seq_adder #(
    parameter int WIDTH  = 4,
    parameter int CHUNKS = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    csa_seq_adder_if.slave bus
);
    localparam int N  = WIDTH * CHUNKS;
    localparam int IW = $clog2(CHUNKS);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t         state;
    logic [N-1:0]   a_reg;
    logic [N-1:0]   b_reg;
    logic [N-1:0]   partial;
    logic [N-1:0]   sum_q;
    logic           cy;
    logic           co_q;
    logic           busy_q;
    logic           done_q;
    logic [IW-1:0]  idx;

    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] ss;
    logic             sco;
    logic [N-1:0]     np;
    logic             last;

    always_comb begin
        sa = '0;
        sb = '0;
        for (int i = 0; i < CHUNKS; i++) begin
            if (idx == IW'(i)) begin
                sa = a_reg[i*WIDTH +: WIDTH];
                sb = b_reg[i*WIDTH +: WIDTH];
            end
        end
    end

    csa #(.WIDTH(WIDTH)) u_csa (
        .a  (sa),
        .b  (sb),
        .ci (cy),
        .s  (ss),
        .co (sco)
    );

    // partial with the current slice merged, so the final edge sees it
    always_comb begin
        np = partial;
        for (int i = 0; i < CHUNKS; i++) begin
            if (idx == IW'(i)) begin
                np[i*WIDTH +: WIDTH] = ss;
            end
        end
    end

    // explicit compare: exit never relies on idx wrapping
    assign last = (idx == IW'(CHUNKS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            a_reg   <= '0;
            b_reg   <= '0;
            partial <= '0;
            sum_q   <= '0;
            cy      <= 1'b0;
            co_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            idx     <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        a_reg   <= bus.a;
                        b_reg   <= bus.b;
                        cy      <= bus.ci;
                        idx     <= '0;
                        partial <= '0;
                        busy_q  <= 1'b1;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    partial <= np;
                    cy      <= sco;
                    idx     <= idx + 1'b1;
                    if (last) begin
`ifdef CSA_SEQ_SAT_EN
                        sum_q <= sco ? '1 : np;
`else
                        sum_q <= np;
`endif
                        co_q   <= sco;
                        done_q <= 1'b1;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.sum  = sum_q;
    assign bus.co   = co_q;
endmodule

// File: tb/tb_csa_seq_adder.sv
// Directed bench for csa_seq_adder: vector table, multi-cycle corner cases,
// and an exhaustive sweep of a WIDTH=1, CHUNKS=3 instance.
module tb_csa_seq_adder;
`ifdef CSA_SEQ_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    csa_seq_adder_if #(.WIDTH(4), .CHUNKS(4)) bus4 ();
    csa_seq_adder_if #(.WIDTH(1), .CHUNKS(3)) bus1 ();

    csa_seq_adder #(.WIDTH(4), .CHUNKS(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus4.slave)
    );

    csa_seq_adder #(.WIDTH(1), .CHUNKS(3)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1.slave)
    );

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        ci;
        logic [15:0] es;
        logic        eco;
    } vec_t;

    vec_t vt[8];

    int checks = 0;
    int failures = 0;
    logic [15:0] held;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Issues one op on the 16-bit DUT, scrambles inputs during RUN,
    // then runs one extra cycle past done.
    task automatic run4(input logic [15:0] a, input logic [15:0] b,
                        input logic ci, output logic [15:0] s,
                        output logic c, output int lat, output int bc,
                        output int hold_err, output logic ok);
        bus4.a = a;
        bus4.b = b;
        bus4.ci = ci;
        bus4.start = 1'b1;
        @(posedge clk);
        #1;
        bus4.start = 1'b0;
        bus4.a = ~a;
        bus4.b = ~b;
        bus4.ci = ~ci;
        lat = 0;
        bc = bus4.busy ? 1 : 0;
        hold_err = 0;
        ok = 1'b0;
        s = '0;
        c = 1'b0;
        for (int i = 0; i < 12 && !ok; i++) begin
            @(posedge clk);
            #1;
            lat++;
            if (bus4.busy) bc++;
            if (bus4.done) begin
                ok = 1'b1;
                s = bus4.sum;
                c = bus4.co;
            end else if (bus4.sum !== held) begin
                hold_err++;
            end
        end
        @(posedge clk);
        #1;
        if (bus4.busy) bc++;
    endtask

    task automatic run1(input logic [2:0] a, input logic [2:0] b,
                        input logic ci, output logic [2:0] s,
                        output logic c, output logic ok);
        bus1.a = a;
        bus1.b = b;
        bus1.ci = ci;
        bus1.start = 1'b1;
        @(posedge clk);
        #1;
        bus1.start = 1'b0;
        ok = 1'b0;
        s = '0;
        c = 1'b0;
        for (int i = 0; i < 10 && !ok; i++) begin
            @(posedge clk);
            #1;
            if (bus1.done) begin
                ok = 1'b1;
                s = bus1.sum;
                c = bus1.co;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [15:0] s;
        logic        c;
        logic        ok;
        int          lat;
        int          bc;
        int          herr;
        int          dn;
        int          bz;
        int          iters;
        logic [15:0] es;

        vt[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0};
        vt[1] = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1};
        vt[2] = '{16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0};
        vt[3] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1};
        vt[4] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1};
        vt[5] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0};
        vt[6] = '{16'hABCD, 16'h1111, 1'b1, 16'hBCDF, 1'b0};
        vt[7] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0};

        bus4.start = 1'b0;
        bus4.a = '0;
        bus4.b = '0;
        bus4.ci = 1'b0;
        bus1.start = 1'b0;
        bus1.a = '0;
        bus1.b = '0;
        bus1.ci = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(bus4.busy), 0);
        chk("rst_done", 32'(bus4.done), 0);
        chk("rst_sum", 32'(bus4.sum), 0);
        chk("rst_co", 32'(bus4.co), 0);
        rst_n = 1'b1;
        held = '0;

        // table ops run back to back: each start lands on the first IDLE cycle
        for (int v = 0; v < 8; v++) begin
            es = (SAT && vt[v].eco) ? 16'hFFFF : vt[v].es;
            run4(vt[v].a, vt[v].b, vt[v].ci, s, c, lat, bc, herr, ok);
            chk($sformatf("v%0d_done", v), 32'(ok), 1);
            chk($sformatf("v%0d_lat", v), 32'(lat), 4);
            chk($sformatf("v%0d_busycyc", v), 32'(bc), 5);
            chk($sformatf("v%0d_sum", v), 32'(s), 32'(es));
            chk($sformatf("v%0d_co", v), 32'(c), 32'(vt[v].eco));
            chk($sformatf("v%0d_hold", v), 32'(herr), 0);
            chk($sformatf("v%0d_busy_after", v), 32'(bus4.busy), 0);
            chk($sformatf("v%0d_done_after", v), 32'(bus4.done), 0);
            held = es;
        end

        // start during RUN is ignored and not queued
        bus4.a = 16'h00FF;
        bus4.b = 16'h0001;
        bus4.ci = 1'b0;
        bus4.start = 1'b1;
        @(posedge clk);
        #1;
        bus4.start = 1'b0;
        @(posedge clk);
        #1;
        bus4.a = 16'h1111;
        bus4.start = 1'b1;
        @(posedge clk);
        #1;
        bus4.start = 1'b0;
        dn = 0;
        bz = 0;
        s = '0;
        c = 1'b1;
        for (int i = 0; i < 15; i++) begin
            if (dn > 0 && !bus4.done && bus4.busy) bz++;
            if (bus4.done) begin
                dn++;
                s = bus4.sum;
                c = bus4.co;
            end
            @(posedge clk);
            #1;
        end
        chk("ign_dones", 32'(dn), 1);
        chk("ign_sum", 32'(s), 32'h0100);
        chk("ign_co", 32'(c), 0);
        chk("ign_noqueue", 32'(bz), 0);

        // async reset at slice 2 discards the op
        bus4.a = 16'h8000;
        bus4.b = 16'h8000;
        bus4.ci = 1'b0;
        bus4.start = 1'b1;
        @(posedge clk);
        #1;
        bus4.start = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        chk("mid_busy_pre", 32'(bus4.busy), 1);
        chk("mid_sum_pre", 32'(bus4.sum), 32'h0100);
        rst_n = 1'b0;
        #1;
        chk("mid_busy", 32'(bus4.busy), 0);
        chk("mid_done", 32'(bus4.done), 0);
        chk("mid_sum", 32'(bus4.sum), 0);
        chk("mid_co", 32'(bus4.co), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        dn = 0;
        bz = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (bus4.done) dn++;
            if (bus4.busy) bz++;
        end
        chk("mid_nodone", 32'(dn), 0);
        chk("mid_nobusy", 32'(bz), 0);
        held = '0;

        // reissue after a reset-aborted op, then immediately again
        run4(16'h1234, 16'h4321, 1'b0, s, c, lat, bc, herr, ok);
        chk("b2b0_sum", 32'(s), 32'h5555);
        chk("b2b0_hold", 32'(herr), 0);
        held = 16'h5555;
        run4(16'h1111, 16'h2222, 1'b0, s, c, lat, bc, herr, ok);
        chk("b2b1_sum", 32'(s), 32'h3333);
        chk("b2b1_lat", 32'(lat), 4);
        chk("b2b1_hold", 32'(herr), 0);

        // exhaustive WIDTH=1, CHUNKS=3
        iters = 0;
        for (int a = 0; a < 8; a++) begin
            for (int b = 0; b < 8; b++) begin
                for (int ci = 0; ci < 2; ci++) begin
                    logic [2:0] s1;
                    logic       c1;
                    logic [3:0] e;
                    logic [2:0] e_s;
                    run1(3'(a), 3'(b), 1'(ci), s1, c1, ok);
                    e = 4'(a) + 4'(b) + 4'(ci);
                    e_s = (SAT && e[3]) ? 3'h7 : e[2:0];
                    chk($sformatf("ex_%0d_%0d_%0d", a, b, ci),
                        32'({ok, c1, s1}), 32'({1'b1, e[3], e_s}));
                    iters++;
                end
            end
        end
        chk("ex_iters", 32'(iters), 128);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/csa_seq_adder.md
# csa_seq_adder

Multi-cycle wide-operand adder controller. It time-shares a single `CSA #(WIDTH)` slice to add two `WIDTH*CHUNKS`-bit operands, one slice per clock, least-significant slice first. The carry is registered between slices. It sits between the stopwatch counting logic and the CSA datapath, trading latency for area on the BASYS3 fabric. The CSA instance lives inside this block and is its only arithmetic resource.

## Interface
- `WIDTH`, default 4: CSA slice width in bits (≥1).
- `CHUNKS`, default 4: number of slices per operation (≥2). Operand width is `N = WIDTH*CHUNKS`.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request pulse; sampled only in IDLE.
- `a`  in  N  operand A; captured on the accepted start edge.
- `b`  in  N  operand B; captured on the accepted start edge.
- `ci`  in  1  carry-in; captured on the accepted start edge.
- `busy`  out  1  high whenever the state is not IDLE.
- `done`  out  1  one-cycle pulse, high in state DONE.
- `sum`  out  N  result of the last completed operation.
- `co`  out  1  carry-out of the last completed operation.

## Operation
- FSM has three states: IDLE, RUN, DONE.
  - IDLE → RUN on `start`=1.
  - RUN → DONE after CHUNKS slice cycles.
  - DONE → IDLE unconditionally.
- On the accepted start:
  - latch `a`, `b` into operand registers;
  - carry register ← `ci`;
  - slice index ← 0;
  - clear the internal partial-sum register.
- In RUN, each cycle:
  - the CSA sees `a_reg[idx*WIDTH +: WIDTH]`, `b_reg[idx*WIDTH +: WIDTH]` and the carry register;
  - the CSA sum is written to `partial[idx*WIDTH +: WIDTH]`;
  - carry register ← CSA `co`;
  - `idx` increments.
- The `idx` counter is `$clog2(CHUNKS)` bits wide. Leaving RUN on the final slice must not depend on `idx` wrap-around.
- On the RUN→DONE edge:
  - `sum` ← final `partial`, including the last slice written on that same edge;
  - `co` ← final carry.
- `sum`/`co` change only on that edge and hold until the next completed operation.
- Arithmetic is unsigned. `{co,sum} = a + b + ci` (mod 2^(N+1)); no overflow is lost.
- `start` in RUN or DONE is ignored and not queued. `a`/`b`/`ci` changing during RUN do not affect the result.
- `rst_n`=0 at any time, including mid-operation:
  - state → IDLE;
  - `busy`=0, `done`=0, `sum`=0, `co`=0;
  - internal registers cleared.
  - The interrupted operation is discarded; no `done` is produced for it.

## Timing
- Reset values: `busy`=0, `done`=0, `sum`=0, `co`=0.
- Let start be accepted at edge k:
  - `busy`=1 from edge k;
  - slices 0..CHUNKS-1 are processed on edges k+1..k+CHUNKS;
  - `done`=1 and new `sum`/`co` are valid from edge k+CHUNKS;
  - `done`=0 and `busy`=0 from edge k+CHUNKS+1.
- Latency from start to done is CHUNKS cycles; busy stays high for CHUNKS+1 cycles.
- Earliest next accepted start is at edge k+CHUNKS+2. This gives a throughput of one operation per CHUNKS+2 cycles.
- `done` never stays high for more than one cycle. `busy` is high while `done` is high.
- The CSA path is combinational within one cycle. The only carry register is between slices; there is no cross-slice combinational path.

## Configuration
- Macro: `CSA_SEQ_SAT_EN`.
- Defined:
  - when the final carry is 1, `sum` ← all ones (2^N−1) on the RUN→DONE edge;
  - `co` still reports 1, so overflow stays visible.
- Undefined: `sum` wraps modulo 2^N and `co` is the raw final carry.
- All other behaviour and timing are identical in both builds.

## Test plan
- WIDTH=4, CHUNKS=4, a=0x1234, b=0x4321, ci=0:
  - `done` pulses 4 cycles after the start edge;
  - sum=0x5555, co=0;
  - busy high for exactly 5 cycles.
- a=0xFFFF, b=0x0000, ci=1 (carry ripples through all slices):
  - without the macro: sum=0x0000, co=1;
  - with `CSA_SEQ_SAT_EN`: sum=0xFFFF, co=1.
- Start a=0x00FF, b=0x0001, then pulse start with a=0x1111 during RUN:
  - exactly one done pulse;
  - sum=0x0100, co=0.
- Start a=0x8000, b=0x8000, then assert rst_n=0 for one cycle at slice 2:
  - busy/done/sum/co all 0 immediately (asynchronous);
  - no done pulse follows.
- Reissue start at the first IDLE cycle after done: result correct; the previous sum is held until the new done.
- Exhaustive check at WIDTH=1, CHUNKS=3: all a, b in 0..7 and ci in {0,1}; every {co,sum} matches a+b+ci. The bench prints pass/fail and also fails if the loop never executed.
